zero_detect_pipe: RTL and testbench

//  Parametrised, pipelined zero/negative detector with architectural flag register.

---
 rtl/zero_detect_pipe.sv | 132 +++++++++++++
 tb/tb_zero_detect_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_detect_pipe.sv
// zero_detect_pipe: pipelined FAN_IN-ary zero/negative detector with Z/N flags.
// Define ZDP_PARITY_EN to add out_parity, reduced through the same pipeline.
module zero_detect_pipe #(
  parameter int WIDTH  = 64,
  parameter int FAN_IN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_set_flags,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic             out_zero,
  output logic             out_neg,
`ifdef ZDP_PARITY_EN
  output logic             out_parity,
`endif
  output logic             flag_z,
  output logic             flag_n
);

  function automatic int lvl_w(input int l);
    int w;
    w = WIDTH;
    for (int i = 0; i <= l; i++) w = (w + FAN_IN - 1) / FAN_IN;
    return w;
  endfunction

  function automatic int num_lvls();
    int n;
    n = 1;
    while (lvl_w(n - 1) > 1) n++;
    return n;
  endfunction

  function automatic int lvl_off(input int l);
    int s;
    s = 0;
    for (int i = 0; i < l; i++) s += lvl_w(i);
    return s;
  endfunction

  localparam int LEVELS = num_lvls();
  localparam int TOT    = lvl_off(LEVELS);

  logic [TOT-1:0]    zq, zd;
  logic [LEVELS-1:0] vq, nq, sq;
`ifdef ZDP_PARITY_EN
  logic [TOT-1:0]    pq, pd;
`endif

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int OW = lvl_w(l);
    localparam int IW = (l == 0) ? WIDTH : lvl_w(l - 1);
    localparam int PW = OW * FAN_IN;
    localparam int OO = lvl_off(l);
    logic [PW-1:0] src;
`ifdef ZDP_PARITY_EN
    logic [PW-1:0] psrc;
`endif
    if (l == 0) begin : g_src0
      assign src = PW'(in_data);
`ifdef ZDP_PARITY_EN
      assign psrc = PW'(in_data);
`endif
    end else begin : g_srcn
      logic [IW-1:0] inv;
      assign inv = ~zq[lvl_off(l - 1) +: IW];
      assign src = ~PW'(inv);
`ifdef ZDP_PARITY_EN
      assign psrc = PW'(pq[lvl_off(l - 1) +: IW]);
`endif
    end
    for (genvar j = 0; j < OW; j++) begin : g_node
      if (l == 0) begin : g_nor
        assign zd[OO+j] = ~|src[j*FAN_IN +: FAN_IN];
      end else begin : g_and
        assign zd[OO+j] = &src[j*FAN_IN +: FAN_IN];
      end
`ifdef ZDP_PARITY_EN
      assign pd[OO+j] = ^psrc[j*FAN_IN +: FAN_IN];
`endif
    end
  end

  // Tree and sideband registers: hold on stall, valids cleared by flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zq <= '0;
      vq <= '0;
      nq <= '0;
      sq <= '0;
`ifdef ZDP_PARITY_EN
      pq <= '0;
`endif
    end else begin
      if (!stall) begin
        zq <= zd;
        nq <= LEVELS'({nq, in_data[WIDTH-1]});
        sq <= LEVELS'({sq, in_set_flags});
`ifdef ZDP_PARITY_EN
        pq <= pd;
`endif
      end
      if (flush)
        vq <= '0;
      else if (!stall)
        vq <= LEVELS'({vq, in_valid});
    end
  end

  assign out_valid = vq[LEVELS-1];
  assign out_zero  = zq[TOT-1];
  assign out_neg   = nq[LEVELS-1];
`ifdef ZDP_PARITY_EN
  assign out_parity = pq[TOT-1];
`endif

  // Architectural flags update only when a flag-setting op really retires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (out_valid && sq[LEVELS-1] && !stall && !flush) begin
      flag_z <= out_zero;
      flag_n <= out_neg;
    end
  end

endmodule

// File: tb/tb_zero_detect_pipe.sv
// tb_zero_detect_pipe: table vectors plus scoreboard for zero_detect_pipe.
// Instances: WIDTH=64/FAN_IN=4 (a) and WIDTH=37/FAN_IN=4 (b).
module tb_zero_detect_pipe;

  typedef struct {
    logic z;
    logic n;
    logic p;
    logic sf;
  } exp_t;

  typedef struct {
    logic [63:0] d;
    logic        sf;
    logic        ez;
    logic        en;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        a_rst, a_v, a_sf, a_st, a_fl;
  logic [63:0] a_d;
  logic        a_ov, a_oz, a_on, a_fz, a_fn;
  logic        b_rst, b_v, b_sf, b_st, b_fl;
  logic [36:0] b_d;
  logic        b_ov, b_oz, b_on, b_fz, b_fn;
`ifdef ZDP_PARITY_EN
  logic        a_op, b_op;
`endif

  zero_detect_pipe #(.WIDTH(64), .FAN_IN(4)) u_a (
    .clk(clk), .reset(a_rst), .in_data(a_d), .in_valid(a_v),
    .in_set_flags(a_sf), .stall(a_st), .flush(a_fl),
    .out_valid(a_ov), .out_zero(a_oz), .out_neg(a_on),
`ifdef ZDP_PARITY_EN
    .out_parity(a_op),
`endif
    .flag_z(a_fz), .flag_n(a_fn)
  );

  zero_detect_pipe #(.WIDTH(37), .FAN_IN(4)) u_b (
    .clk(clk), .reset(b_rst), .in_data(b_d), .in_valid(b_v),
    .in_set_flags(b_sf), .stall(b_st), .flush(b_fl),
    .out_valid(b_ov), .out_zero(b_oz), .out_neg(b_on),
`ifdef ZDP_PARITY_EN
    .out_parity(b_op),
`endif
    .flag_z(b_fz), .flag_n(b_fn)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d",
               name, act, exp, cyc);
    end
  endtask

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic efz_a = 1'b0, efn_a = 1'b0;
  logic efz_b = 1'b0, efn_b = 1'b0;
  int   pops_a = 0, ret_a = 0;
  int   pops_b = 0;

  always @(negedge clk) begin
    if (a_rst) begin
      chk("a_flag_z", a_fz, efz_a);
      chk("a_flag_n", a_fn, efn_a);
      if (a_ov) begin
        if (qa.size() == 0) begin
          chk("a_unexpected_valid", a_ov, 0);
        end else begin
          chk("a_out_zero", a_oz, qa[0].z);
          chk("a_out_neg", a_on, qa[0].n);
`ifdef ZDP_PARITY_EN
          chk("a_out_parity", a_op, qa[0].p);
`endif
          if (!a_st && !a_fl) begin
            ea = qa.pop_front();
            pops_a++;
            ret_a = cyc;
            if (ea.sf) begin
              efz_a = ea.z;
              efn_a = ea.n;
            end
          end
        end
      end
      if (a_fl) qa.delete();
    end
  end

  always @(negedge clk) begin
    if (b_rst) begin
      chk("b_flag_z", b_fz, efz_b);
      chk("b_flag_n", b_fn, efn_b);
      if (b_ov) begin
        if (qb.size() == 0) begin
          chk("b_unexpected_valid", b_ov, 0);
        end else begin
          chk("b_out_zero", b_oz, qb[0].z);
          chk("b_out_neg", b_on, qb[0].n);
`ifdef ZDP_PARITY_EN
          chk("b_out_parity", b_op, qb[0].p);
`endif
          if (!b_st && !b_fl) begin
            eb = qb.pop_front();
            pops_b++;
            if (eb.sf) begin
              efz_b = eb.z;
              efn_b = eb.n;
            end
          end
        end
      end
      if (b_fl) qb.delete();
    end
  end

  task automatic step_a(input logic [63:0] d, input logic v, input logic sf,
                        input logic st, input logic fl,
                        input logic ez, input logic en);
    @(posedge clk);
    #1;
    a_d = d; a_v = v; a_sf = sf; a_st = st; a_fl = fl;
    if (v && !st && !fl) qa.push_back('{ez, en, ^d, sf});
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) step_a('0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic step_b(input logic [36:0] d, input logic v, input logic sf,
                        input logic st, input logic fl);
    @(posedge clk);
    #1;
    b_d = d; b_v = v; b_sf = sf; b_st = st; b_fl = fl;
    if (v && !st && !fl) qb.push_back('{(d == '0), d[36], ^d, sf});
  endtask

  task automatic idle_b(input int n);
    for (int i = 0; i < n; i++) step_b('0, 0, 0, 0, 0);
  endtask

  vec_t va[9];
  int   c0, p0;
  logic [36:0] bw;

  initial begin
    va[0] = '{64'h0, 1'b1, 1'b1, 1'b0};
    va[1] = '{64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1};
    va[2] = '{64'h1, 1'b0, 1'b0, 1'b0};
    va[3] = '{64'h0, 1'b0, 1'b1, 1'b0};
    va[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1};
    va[5] = '{64'h0000_0001_0000_0000, 1'b1, 1'b0, 1'b0};
    va[6] = '{64'h0010_0000_0000_0000, 1'b0, 1'b0, 1'b0};
    va[7] = '{64'h4000_0000_0000_0000, 1'b1, 1'b0, 1'b0};
    va[8] = '{64'h0, 1'b1, 1'b1, 1'b0};

    a_rst = 0; a_d = '0; a_v = 0; a_sf = 0; a_st = 0; a_fl = 0;
    b_rst = 0; b_d = '0; b_v = 0; b_sf = 0; b_st = 0; b_fl = 0;
    #2;
    chk("a_rst_valid", a_ov, 0);
    chk("a_rst_zero", a_oz, 0);
    chk("a_rst_neg", a_on, 0);
    chk("a_rst_fz", a_fz, 0);
    chk("a_rst_fn", a_fn, 0);
    chk("b_rst_valid", b_ov, 0);
    chk("b_rst_zero", b_oz, 0);
    chk("b_rst_fz", b_fz, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    a_rst = 1;
    b_rst = 1;

    // Exact latency and flag update on an empty pipeline.
    step_a(64'h0, 1, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      idle_a(1);
      @(negedge clk);
      chk("a_latency_valid", a_ov, (k == 3));
      if (k == 4) begin
        chk("a_t1_flag_z", a_fz, 1);
        chk("a_t1_flag_n", a_fn, 0);
      end
    end

    // Back-to-back table vectors, one per cycle.
    for (int i = 0; i < 9; i++)
      step_a(va[i].d, 1, va[i].sf, 0, 0, va[i].ez, va[i].en);
    idle_a(6);
    chk("a_table_drained", qa.size(), 0);

    // Stall two cycles while the op sits at the output.
    p0 = pops_a;
    step_a(64'h5, 1, 1, 0, 0, 0, 0);
    c0 = cyc;
    idle_a(2);
    step_a(64'hDEAD, 1, 1, 1, 0, 0, 0);
    step_a(64'hDEAD, 1, 1, 1, 0, 0, 0);
    idle_a(4);
    chk("a_stall_pulses", pops_a - p0, 1);
    chk("a_stall_retire_cyc", ret_a - c0, 5);

    // Flush kills in-flight ops; flags must not change.
    p0 = pops_a;
    step_a(64'h0, 1, 1, 0, 0, 1, 0);
    step_a('0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      idle_a(1);
      @(negedge clk);
      chk("a_flush_no_valid", a_ov, 0);
    end
    step_a(64'h0, 1, 1, 0, 0, 1, 0);
    step_a('0, 0, 0, 1, 1, 0, 0);
    step_a(64'h0, 1, 1, 0, 1, 1, 0);
    for (int k = 0; k < 5; k++) begin
      idle_a(1);
      @(negedge clk);
      chk("a_flush_stall_no_valid", a_ov, 0);
    end
    chk("a_flush_pops", pops_a - p0, 0);
    chk("a_flush_flag_z", a_fz, 0);

    // Walking one on the 37-bit instance, then all zeros.
    for (int i = 0; i < 37; i++) begin
      bw = 37'd1 << i;
      step_b(bw, 1, 1, 0, 0);
    end
    step_b('0, 1, 1, 0, 0);
    idle_b(5);
    chk("b_walk_pops", pops_b, 38);
    chk("b_walk_flag_z", b_fz, 1);

    // Reset in the middle of a stream.
    bw = 37'h10_0000_0001;
    step_b(bw, 1, 1, 0, 0);
    step_b(bw, 1, 1, 0, 0);
    step_b(bw, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    b_rst = 0;
    b_d = '0; b_v = 0; b_sf = 0; b_st = 0; b_fl = 0;
    #1;
    chk("b_mid_rst_valid", b_ov, 0);
    chk("b_mid_rst_zero", b_oz, 0);
    chk("b_mid_rst_neg", b_on, 0);
    chk("b_mid_rst_fz", b_fz, 0);
    chk("b_mid_rst_fn", b_fn, 0);
    qb.delete();
    efz_b = 0;
    efn_b = 0;
    @(posedge clk);
    #1;
    b_rst = 1;
    for (int k = 0; k < 5; k++) begin
      idle_b(1);
      @(negedge clk);
      chk("b_no_stale_valid", b_ov, 0);
    end
    p0 = pops_b;
    step_b(37'h1F, 1, 1, 0, 0);
    idle_b(5);
    chk("b_post_rst_pops", pops_b - p0, 1);
    chk("b_drained", qb.size(), 0);
    chk("a_drained", qa.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
